// File: rtl/uart_ctrl_pkg.sv
// Shared types for the UART control blocks.
//   arb_state_t : transmit arbiter states
//   BYTE_W      : width of one UART byte lane
package uart_ctrl_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    DRAIN = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker. Returns the first set bit of cand at or
// after ptr, searching upward with wrap.
// Ports:
//   cand   in  N   candidate requests
//   ptr    in  IW  highest-priority index this round
//   winner out N   one-hot winner, zero when cand is zero
//   idx    out IW  index of winner (0 when none)
//   any    out 1   cand is non-zero
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  cand,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  winner,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] pos;

  // Walk offsets from farthest to nearest so the nearest hit is kept last.
  always_comb begin
    pos = '0;
    idx = '0;
    any = |cand;
    for (int i = N - 1; i >= 0; i--) begin
      pos = IW'((int'(ptr) + i) % N);
      if (cand[pos]) idx = pos;
    end
    winner = any ? (N'(1) << idx) : '0;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one UART TX FIFO between NUM_REQ
// byte streams, with optional drain/guard turnaround and a stall watchdog.
// Ports:
//   clk_i        in   system clock
//   rst_ni       in   synchronous active-low reset
//   en_mask_i    in   per-requester arbitration enable (sampled in IDLE only)
//   req_valid_i  in   requester byte valid
//   req_data_i   in   requester bytes, requester k on [8k+7:8k]
//   req_last_i   in   final byte of packet
//   req_ready_o  out  byte accepted when valid & ready
//   grant_o      out  one-hot current owner, zero when none
//   tx_we_o      out  UART FIFO write strobe
//   tx_data_o    out  UART FIFO write data
//   tx_full_i    in   UART FIFO full
//   tx_empty_i   in   UART FIFO empty
//   busy_o       out  arbiter not idle
//   stall_err_o  out  one-cycle pulse on watchdog abort
//
// state | meaning
// IDLE  | no owner; pick winner among enabled valid requesters
// XFER  | owner streams bytes into FIFO until last byte or watchdog abort
// DRAIN | wait for FIFO empty, then GUARD_CYCLES more empty cycles
module uart_tx_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter int NUM_REQ         = 4,
  parameter int DRAIN_ON_SWITCH = 1,
  parameter int GUARD_CYCLES    = 16,
  parameter int STALL_TIMEOUT   = 1024
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NUM_REQ-1:0]        en_mask_i,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [BYTE_W*NUM_REQ-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]        req_last_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic [NUM_REQ-1:0]        grant_o,
  output logic                      tx_we_o,
  output logic [BYTE_W-1:0]         tx_data_o,
  input  logic                      tx_full_i,
  input  logic                      tx_empty_i,
  output logic                      busy_o,
  output logic                      stall_err_o
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SW = ($clog2(STALL_TIMEOUT + 1) < 1) ? 1 : $clog2(STALL_TIMEOUT + 1);
  localparam int GW = ($clog2(GUARD_CYCLES + 1) < 1) ? 1 : $clog2(GUARD_CYCLES + 1);
  localparam logic [SW-1:0] STALL_LAST = SW'(STALL_TIMEOUT - 1);
  localparam logic [GW-1:0] GUARD_LOAD = GW'(GUARD_CYCLES);
  localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_REQ - 1);

  arb_state_t    state;
  logic [IW-1:0] gidx;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] next_ptr;
  logic [SW-1:0] stall_cnt;
  logic [GW-1:0] guard_cnt;

  logic [NUM_REQ-1:0] arb_winner;
  logic [IW-1:0]      arb_idx;
  logic               arb_any;

  logic in_xfer, g_valid, g_last, accept, stall_hit, pkt_end;

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
    .cand   (req_valid_i & en_mask_i),
    .ptr    (rr_ptr),
    .winner (arb_winner),
    .idx    (arb_idx),
    .any    (arb_any)
  );

  assign in_xfer   = (state == XFER);
  assign g_valid   = |(req_valid_i & grant_o);
  assign g_last    = |(req_last_i & grant_o);
  assign accept    = in_xfer & g_valid & ~tx_full_i;
  // Expiry needs valid low, so a same-cycle accepted last byte always wins.
  assign stall_hit = in_xfer & ~g_valid & (stall_cnt == STALL_LAST);
  assign pkt_end   = (accept & g_last) | stall_hit;
  assign next_ptr  = (gidx == LAST_IDX) ? '0 : gidx + IW'(1);

  assign req_ready_o = (in_xfer && !tx_full_i) ? grant_o : '0;
  assign tx_we_o     = accept;
  assign busy_o      = (state != IDLE);

  // Zero-latency byte path from the owner to the FIFO.
  always_comb begin
    tx_data_o = '0;
    if (in_xfer) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (grant_o[k]) tx_data_o = req_data_i[k*BYTE_W +: BYTE_W];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state       <= IDLE;
      grant_o     <= '0;
      gidx        <= '0;
      rr_ptr      <= '0;
      stall_cnt   <= '0;
      guard_cnt   <= '0;
      stall_err_o <= 1'b0;
    end else begin
      stall_err_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (arb_any) begin
            grant_o   <= arb_winner;
            gidx      <= arb_idx;
            stall_cnt <= '0;
            state     <= XFER;
          end
        end
        XFER: begin
          if (pkt_end) begin
            grant_o     <= '0;
            rr_ptr      <= next_ptr;
            stall_cnt   <= '0;
            stall_err_o <= stall_hit;
            guard_cnt   <= GUARD_LOAD;
            state       <= (DRAIN_ON_SWITCH != 0) ? DRAIN : IDLE;
          end else if (accept) begin
            stall_cnt <= '0;
          end else if (!g_valid) begin
            stall_cnt <= stall_cnt + 1'b1;
          end
        end
        DRAIN: begin
          // Any non-empty cycle (including an external writer) restarts the guard.
          if (!tx_empty_i)            guard_cnt <= GUARD_LOAD;
          else if (guard_cnt == '0)   state     <= IDLE;
          else                        guard_cnt <= guard_cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: requester drivers stream byte queues,
// a packet-level round-robin model predicts the FIFO write sequence, and a
// monitor pops and compares on every FIFO write.
module tb_uart_tx_arbiter;

  localparam int NR    = 4;
  localparam int GUARD = 4;
  localparam int ST    = 6;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic [NR-1:0]     en_mask_i = '1;
  logic [NR-1:0]     req_valid_i = '0;
  logic [8*NR-1:0]   req_data_i = '0;
  logic [NR-1:0]     req_last_i = '0;
  logic [NR-1:0]     req_ready_o;
  logic [NR-1:0]     grant_o;
  logic              tx_we_o;
  logic [7:0]        tx_data_o;
  logic              tx_full_i = 1'b0;
  logic              tx_empty_i = 1'b1;
  logic              busy_o;
  logic              stall_err_o;

  always #5 clk_i = ~clk_i;

  uart_tx_arbiter #(
    .NUM_REQ(NR), .DRAIN_ON_SWITCH(1), .GUARD_CYCLES(GUARD), .STALL_TIMEOUT(ST)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .en_mask_i(en_mask_i),
    .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_last_i(req_last_i),
    .req_ready_o(req_ready_o), .grant_o(grant_o), .tx_we_o(tx_we_o),
    .tx_data_o(tx_data_o), .tx_full_i(tx_full_i), .tx_empty_i(tx_empty_i),
    .busy_o(busy_o), .stall_err_o(stall_err_o)
  );

  typedef struct { logic [7:0] d; bit last; int gap; } ent_t;
  typedef struct { int req; logic [7:0] d; } exp_t;

  ent_t          rq[NR][$];
  exp_t          exp_q[$];
  logic [NR-1:0] hs = '0;
  bit            loaded[NR];
  int            gap_left[NR];
  int            full_mode = 0;
  int            m_ptr = 0;
  int            stall_cyc = 0;
  int            n_chk = 0;
  int            n_pass = 0;

  task automatic chk(input bit ok, input string name, input string msg);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: %s", name, msg);
  endtask

  task automatic step();
    @(negedge clk_i);
    #3;
  endtask

  task automatic add_bytes(input int k, input logic [7:0] d, input bit last, input int gap);
    ent_t e;
    e.d = d; e.last = last; e.gap = gap;
    rq[k].push_back(e);
  endtask

  task automatic add_pkt(input int k, input int len, input int max_gap);
    for (int b = 0; b < len; b++)
      add_bytes(k, 8'($urandom), (b == len - 1), (b == 0) ? 0 : int'($urandom_range(max_gap, 0)));
  endtask

  // Packet-level reference: every enabled requester with a pending packet is
  // a candidate; pick the first at or after the pointer, then move past it.
  function automatic void build_expected(input logic [NR-1:0] mask);
    int off[NR];
    int found;
    int k;
    bit lst;
    exp_t e;
    for (int i = 0; i < NR; i++) off[i] = 0;
    for (int round = 0; round < 1000; round++) begin
      found = -1;
      for (int i = 0; i < NR; i++) begin
        k = (m_ptr + i) % NR;
        if (found < 0 && mask[k] && off[k] < rq[k].size()) found = k;
      end
      if (found < 0) break;
      lst = 1'b0;
      while (!lst && off[found] < rq[found].size()) begin
        e.req = found;
        e.d   = rq[found][off[found]].d;
        lst   = rq[found][off[found]].last;
        exp_q.push_back(e);
        off[found]++;
      end
      m_ptr = (found + 1) % NR;
    end
  endfunction

  task automatic push_exp(input int r, input logic [7:0] d);
    exp_t e;
    e.req = r; e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic clear_disabled(input logic [NR-1:0] mask);
    for (int k = 0; k < NR; k++)
      if (!mask[k]) begin rq[k].delete(); loaded[k] = 1'b0; end
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy_o) && n < 3000) begin step(); n++; end
    chk(n < 3000, name, $sformatf("timeout with %0d bytes still expected, busy=%0b", exp_q.size(), busy_o));
  endtask

  task automatic wait_grant(input logic [NR-1:0] want, input string name);
    int n = 0;
    while (grant_o != want && n < 300) begin
      if (grant_o == '0 && !busy_o && req_valid_i != '0)
        chk(!tx_we_o && req_ready_o == '0, "idle_no_xfer",
            $sformatf("we=%0b ready=%b in idle, want 0", tx_we_o, req_ready_o));
      step(); n++;
    end
    chk(grant_o == want, name, $sformatf("grant=%b, want %b", grant_o, want));
  endtask

  task automatic chk_zero(input string name);
    chk(grant_o == '0 && req_ready_o == '0 && !tx_we_o && tx_data_o == 8'h00 && !busy_o && !stall_err_o,
        name, $sformatf("grant=%b ready=%b we=%0b data=%h busy=%0b stall=%0b, want all 0",
                        grant_o, req_ready_o, tx_we_o, tx_data_o, busy_o, stall_err_o));
  endtask

  // Requester drivers and FIFO full source.
  initial begin
    forever begin
      @(negedge clk_i);
      for (int k = 0; k < NR; k++)
        if (hs[k] && rq[k].size() > 0) begin void'(rq[k].pop_front()); loaded[k] = 1'b0; end
      case (full_mode)
        1:       tx_full_i = ($urandom_range(3, 0) == 0);
        2:       tx_full_i = 1'b1;
        default: tx_full_i = 1'b0;
      endcase
      for (int k = 0; k < NR; k++) begin
        req_valid_i[k] = 1'b0;
        req_last_i[k]  = 1'b0;
        req_data_i[k*8 +: 8] = 8'h00;
        if (rq[k].size() > 0) begin
          if (!loaded[k]) begin gap_left[k] = rq[k][0].gap; loaded[k] = 1'b1; end
          if (gap_left[k] > 0) gap_left[k]--;
          else begin
            req_valid_i[k] = 1'b1;
            req_last_i[k]  = rq[k][0].last;
            req_data_i[k*8 +: 8] = rq[k][0].d;
          end
        end
      end
      #1;
      hs = req_valid_i & req_ready_o;
    end
  end

  // Monitor: scoreboard pop on every FIFO write, plus output rules.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      #1;
      if (tx_we_o) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "sb_extra", $sformatf("write %h from grant %b, want no write", tx_data_o, grant_o));
        end else begin
          e = exp_q.pop_front();
          chk(tx_data_o == e.d && grant_o == NR'(1) << e.req, "sb_byte",
              $sformatf("data=%h grant=%b, want data=%h grant=%b", tx_data_o, grant_o, e.d, NR'(1) << e.req));
        end
      end
      if (tx_full_i)
        chk(!tx_we_o && req_ready_o == '0, "full_blocks",
            $sformatf("we=%0b ready=%b while full, want 0", tx_we_o, req_ready_o));
      if (req_ready_o != '0)
        chk((req_ready_o & ~grant_o) == '0, "ready_owner",
            $sformatf("ready=%b grant=%b, want ready within grant", req_ready_o, grant_o));
      if (stall_err_o) begin
        stall_cyc++;
        chk(grant_o == '0, "stall_release", $sformatf("grant=%b at stall pulse, want 0", grant_o));
      end
    end
  end

  initial begin
    logic [7:0]    s1v[3];
    bit            s1e[6];
    logic [NR-1:0] mask;
    int            n;
    s1v = '{8'hA1, 8'hA2, 8'hA3};
    s1e = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    repeat (3) step();
    chk_zero("reset_hold");
    rst_ni = 1'b1;
    step();
    chk_zero("reset_release");

    // Three-byte packet from requester 0, then drain with empty glitches.
    m_ptr = 0;
    add_bytes(0, 8'hA1, 1'b0, 0);
    add_bytes(0, 8'hA2, 1'b0, 0);
    add_bytes(0, 8'hA3, 1'b1, 0);
    build_expected('1);
    wait_grant(4'b0001, "s1_grant");
    for (int i = 0; i < 3; i++) begin
      chk(tx_we_o && tx_data_o == s1v[i] && busy_o, "s1_burst",
          $sformatf("beat %0d we=%0b data=%h, want we=1 data=%h", i, tx_we_o, tx_data_o, s1v[i]));
      step();
    end
    chk(grant_o == '0 && busy_o, "s1_drain_entry",
        $sformatf("grant=%b busy=%0b, want grant=0 busy=1", grant_o, busy_o));
    n = 0;
    while (busy_o && n < 100) begin
      tx_empty_i = (n < 6) ? s1e[n] : 1'b1;
      step(); n++;
    end
    tx_empty_i = 1'b1;
    chk(n == GUARD + 7, "s1_drain_len", $sformatf("drain lasted %0d cycles, want %0d", n, GUARD + 7));
    wait_done("s1_done");

    // FIFO full held mid-packet longer than the stall timeout.
    for (int b = 0; b < 6; b++) add_bytes(1, 8'(8'h10 + b), (b == 5), 0);
    build_expected('1);
    wait_grant(4'b0010, "full_grant");
    step(); step();
    full_mode = 2;
    repeat (ST + 3) begin
      step();
      chk(grant_o == 4'b0010 && !tx_we_o && req_ready_o == '0, "full_hold",
          $sformatf("grant=%b we=%0b ready=%b, want grant=0010 we=0 ready=0", grant_o, tx_we_o, req_ready_o));
    end
    full_mode = 0;
    wait_done("full_done");
    chk(stall_cyc == 0, "full_no_stall", $sformatf("stall cycles=%0d, want 0", stall_cyc));

    // Watchdog: requester 2 stalls after one byte; requester 3 goes next.
    add_bytes(2, 8'h55, 1'b0, 0);
    add_bytes(2, 8'h66, 1'b1, ST + 3);
    add_bytes(3, 8'h31, 1'b0, 0);
    add_bytes(3, 8'h32, 1'b1, 0);
    push_exp(2, 8'h55);
    push_exp(3, 8'h31);
    push_exp(3, 8'h32);
    push_exp(2, 8'h66);
    m_ptr = 3;
    wait_done("stall_done");
    chk(stall_cyc == 1, "stall_pulse", $sformatf("stall cycles=%0d, want 1", stall_cyc));

    // Enable mask 1010; requester 1 disabled mid-packet still completes.
    en_mask_i = 4'b1010;
    add_pkt(0, 2, 0);
    add_pkt(2, 2, 0);
    add_pkt(1, 5, 0);
    add_pkt(3, 2, 0);
    add_pkt(3, 2, 0);
    build_expected(4'b1010);
    wait_grant(4'b0010, "mask_grant1");
    en_mask_i = 4'b1000;
    wait_done("mask_done");
    clear_disabled(4'b1000);
    step();
    en_mask_i = '1;

    // Randomized rounds with random backpressure and mid-packet gaps.
    full_mode = 1;
    for (int r = 0; r < 6; r++) begin
      mask = NR'($urandom_range(15, 1));
      for (int k = 0; k < NR; k++) begin
        n = int'($urandom_range(2, 0));
        for (int p = 0; p < n; p++) add_pkt(k, int'($urandom_range(4, 1)), ST - 2);
      end
      en_mask_i = mask;
      build_expected(mask);
      wait_done("rand_done");
      clear_disabled(mask);
      step();
      en_mask_i = '1;
    end
    full_mode = 0;
    chk(stall_cyc == 1, "no_extra_stall", $sformatf("stall cycles=%0d, want 1", stall_cyc));

    // Reset mid-XFER, then arbitration restarts from requester 0.
    add_bytes(2, 8'h77, 1'b1, 0);
    build_expected('1);
    wait_done("pre_rst_done");
    for (int b = 0; b < 12; b++) add_bytes(1, 8'(8'h80 + b), (b == 11), 0);
    build_expected('1);
    wait_grant(4'b0010, "rst_grant");
    step(); step();
    rst_ni = 1'b0;
    for (int k = 0; k < NR; k++) begin rq[k].delete(); loaded[k] = 1'b0; end
    exp_q.delete();
    hs = '0;
    step();
    rst_ni = 1'b1;
    chk_zero("rst_mid");
    for (int k = 0; k < NR; k++) begin
      add_bytes(k, 8'(8'hC0 + k), 1'b1, 0);
      add_bytes(k, 8'(8'hD0 + k), 1'b1, 0);
    end
    m_ptr = 0;
    build_expected('1);
    wait_done("rst_restart");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
